// File: rtl/hps_ext_pkg.sv
// Shared opcode offsets, tags and sample layout for the HPS extension-bus bridge.
package hps_ext_pkg;

  localparam int unsigned OP_WR   = 0;
  localparam int unsigned OP_RD   = 1;
  localparam int unsigned OP_CTRL = 2;
  localparam int unsigned OP_STAT = 3;

  localparam logic [7:0] STREAM_TAG  = 8'hF0;
  localparam logic [3:0] STAT_PREFIX = 4'hE;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] l;
  } sample_t;

  // Per-channel status word returned by the status command.
  function automatic logic [15:0] chan_status(input logic ovf, input logic [11:0] free_cnt);
    return {ovf, 3'b000, free_cnt};
  endfunction

endpackage

// File: rtl/hps_ext_fifo.sv
// First-word fall-through stereo sample FIFO with level, request and sticky overflow.
module hps_ext_fifo
  import hps_ext_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  sample_t          push_data_i,
  input  logic             pop_i,
  input  logic             ovf_clr_i,
  output logic             valid_o,
  output sample_t          data_o,
  output logic [FIFO_AW:0] level_o,
  output logic             ovf_o,
  output logic             req_o
);

  localparam int unsigned      Depth   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] HalfLvl = (FIFO_AW + 1)'(Depth / 2);

  sample_t          mem_q [Depth];
  logic [FIFO_AW:0] wptr_q, wptr_d;
  logic [FIFO_AW:0] rptr_q, rptr_d;
  sample_t          data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, pop, push_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop     = ~empty & pop_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push_i & (~full | pop);

  always_comb begin
    wptr_d = push_ok ? wptr_q + PtrOne : wptr_q;
    rptr_d = pop ? rptr_q + PtrOne : rptr_q;
    if (push_ok && (rptr_d == wptr_q)) begin
      data_d = push_data_i;
    end else begin
      data_d = mem_q[rptr_d[FIFO_AW-1:0]];
    end
    ovf_d = ovf_q;
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (push_i && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign valid_o = ~empty;
  assign data_o  = data_q;
  assign level_o = wptr_q - rptr_q;
  assign ovf_o   = ovf_q;
  assign req_o   = (level_o <= HalfLvl);

endmodule

// File: rtl/hps_ext_mc.sv
// HPS extension-bus bridge: memory bursts, control writes and multi-channel audio streams.
module hps_ext_mc
  import hps_ext_pkg::*;
#(
  parameter int unsigned CMD_BASE = 'h61,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  inout  wire  [35:0]           EXT_BUS,
  input  logic [15:0]           ext_din,
  output logic [15:0]           ext_dout,
  output logic [15:0]           ext_addr,
  output logic                  ext_rd,
  output logic                  ext_wr,
  output logic                  ext_midi,
  input  logic [7:0]            ext_req,
  input  logic [1:0]            ext_hotswap,
  output logic [NUM_CH-1:0]     aud_valid,
  input  logic [NUM_CH-1:0]     aud_ready,
  output logic [32*NUM_CH-1:0]  aud_data,
  output logic [NUM_CH-1:0]     aud_req
);

  localparam int unsigned Depth   = 1 << FIFO_AW;
  localparam logic [15:0] CmdWr   = 16'(CMD_BASE + OP_WR);
  localparam logic [15:0] CmdRd   = 16'(CMD_BASE + OP_RD);
  localparam logic [15:0] CmdCtrl = 16'(CMD_BASE + OP_CTRL);
  localparam logic [15:0] CmdStat = 16'(CMD_BASE + OP_STAT);

  logic [15:0] din;
  logic        io_strobe, io_enable;

  assign din       = EXT_BUS[31:16];
  assign io_strobe = EXT_BUS[33];
  assign io_enable = |EXT_BUS[35:34];

  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] io_dout_q, io_dout_d;
  logic        dout_en_q, dout_en_d;
  logic [15:0] ext_dout_q, ext_dout_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic        ext_rd_q, ext_rd_d;
  logic        ext_wr_q, ext_wr_d;
  logic        ext_midi_q, ext_midi_d;
  logic        strm_act_q, strm_act_d;
  logic [1:0]  strm_ch_q, strm_ch_d;
  logic        lrck_q, lrck_d;
  logic [15:0] smp_l_q, smp_l_d;

  logic [NUM_CH-1:0] push, ovf_clr, ovf;
  logic [FIFO_AW:0]  level [NUM_CH];
  sample_t           head  [NUM_CH];
  sample_t           push_data;
  logic [7:0]        tag_off;
  logic [2:0]        stat_ch;

  assign EXT_BUS[15:0] = io_dout_q;
  assign EXT_BUS[32]   = dout_en_q;

  assign push_data = '{r: din, l: smp_l_q};

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    cmd_d      = cmd_q;
    io_dout_d  = io_dout_q;
    dout_en_d  = dout_en_q;
    ext_dout_d = ext_dout_q;
    ext_addr_d = ext_addr_q;
    ext_rd_d   = 1'b0;
    ext_wr_d   = 1'b0;
    ext_midi_d = ext_midi_q;
    strm_act_d = strm_act_q;
    strm_ch_d  = strm_ch_q;
    lrck_d     = lrck_q;
    smp_l_d    = smp_l_q;
    push       = '0;
    ovf_clr    = '0;
    tag_off    = din[15:8] - STREAM_TAG;
    stat_ch    = byte_cnt_q - 3'd2;

    // Auto-increment saturates inside the wrap window; upper address bits never change.
    if ((ext_rd_q || ext_wr_q) && (ext_addr_q[WRAP_W-1:0] != '1)) begin
      ext_addr_d[WRAP_W-1:0] = ext_addr_q[WRAP_W-1:0] + WRAP_W'(1);
    end

    if (!io_enable) begin
      byte_cnt_d = 3'd0;
      io_dout_d  = 16'h0000;
      dout_en_d  = 1'b0;
      strm_act_d = 1'b0;
      lrck_d     = 1'b0;
    end else if (io_strobe) begin
      ext_dout_d = din;
      io_dout_d  = 16'h0000;
      if (byte_cnt_q != 3'd7) begin
        byte_cnt_d = byte_cnt_q + 3'd1;
      end

      if (byte_cnt_q == 3'd0) begin
        cmd_d     = din;
        dout_en_d = (din >= CmdWr) && (din <= CmdStat);
        io_dout_d = {STAT_PREFIX, 1'b0, |aud_req, ext_hotswap, ext_req};
      end

      if (byte_cnt_q == 3'd1) begin
        ext_addr_d = din;
        strm_act_d = (din[15:8] >= STREAM_TAG) && (32'(tag_off) < NUM_CH);
        strm_ch_d  = tag_off[1:0];
        if (cmd_q == CmdCtrl) begin
          ext_midi_d = din[7];
        end
      end

      if (byte_cnt_q >= 3'd3) begin
        if (cmd_q == CmdWr) begin
          if (strm_act_q) begin
            lrck_d = ~lrck_q;
            if (!lrck_q) begin
              smp_l_d = din;
            end else begin
              for (int c = 0; c < NUM_CH; c++) begin
                if (strm_ch_q == 2'(c)) begin
                  push[c] = 1'b1;
                end
              end
            end
          end else begin
            ext_wr_d = 1'b1;
          end
        end
        if (cmd_q == CmdRd) begin
          io_dout_d = ext_din;
          ext_rd_d  = 1'b1;
        end
      end

      // Channels past NUM_CH leave the word at its zero default.
      if ((byte_cnt_q >= 3'd2) && (cmd_q == CmdStat)) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (stat_ch == 3'(c)) begin
            io_dout_d  = chan_status(ovf[c], 12'(Depth) - 12'(level[c]));
            ovf_clr[c] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_cnt_q <= 3'd0;
      cmd_q      <= 16'h0000;
      io_dout_q  <= 16'h0000;
      dout_en_q  <= 1'b0;
      ext_dout_q <= 16'h0000;
      ext_addr_q <= 16'h0000;
      ext_rd_q   <= 1'b0;
      ext_wr_q   <= 1'b0;
      ext_midi_q <= 1'b0;
      strm_act_q <= 1'b0;
      strm_ch_q  <= 2'd0;
      lrck_q     <= 1'b0;
      smp_l_q    <= 16'h0000;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      cmd_q      <= cmd_d;
      io_dout_q  <= io_dout_d;
      dout_en_q  <= dout_en_d;
      ext_dout_q <= ext_dout_d;
      ext_addr_q <= ext_addr_d;
      ext_rd_q   <= ext_rd_d;
      ext_wr_q   <= ext_wr_d;
      ext_midi_q <= ext_midi_d;
      strm_act_q <= strm_act_d;
      strm_ch_q  <= strm_ch_d;
      lrck_q     <= lrck_d;
      smp_l_q    <= smp_l_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hps_ext_fifo #(
      .FIFO_AW (FIFO_AW)
    ) u_fifo (
      .clk_i       (clk_sys),
      .rst_i       (reset),
      .push_i      (push[c]),
      .push_data_i (push_data),
      .pop_i       (aud_ready[c]),
      .ovf_clr_i   (ovf_clr[c]),
      .valid_o     (aud_valid[c]),
      .data_o      (head[c]),
      .level_o     (level[c]),
      .ovf_o       (ovf[c]),
      .req_o       (aud_req[c])
    );
    assign aud_data[32*c +: 32] = head[c];
  end

  assign ext_dout = ext_dout_q;
  assign ext_addr = ext_addr_q;
  assign ext_rd   = ext_rd_q;
  assign ext_wr   = ext_wr_q;
  assign ext_midi = ext_midi_q;

endmodule
